pmcc_sequencer: RTL

- Upstream instruction sequencer of the PMC coprocessor.
- Fetches 32-bit words from the coprocessor code RAM, decodes them, and runs timing and flow control: waits, counted loops, jumps and halt.
- For every STORE instruction it drives a one-cycle `store` strobe together with the 32-bit `instr` word. These feed the matrix-control register stage, which latches `instr[23:8]` into the matrix control lines.

---
 rtl/pmcc_sequencer_if.sv | 26 ++
 rtl/pmcc_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pmcc_sequencer_if.sv
// rtl/pmcc_sequencer_if.sv - code RAM read port and STORE strobe bundle of the PMC sequencer
interface pmcc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              store;
    logic [31:0]       instr;

    modport master (
        output mem_req,
        output mem_addr,
        output store,
        output instr,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  store,
        input  instr,
        output mem_rdata
    );
endinterface

// File: rtl/pmcc_sequencer.sv
// rtl/pmcc_sequencer.sv - PMC coprocessor instruction sequencer; PMCC_SEQ_STEP_EN adds single-step hold
module pmcc_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
`ifdef PMCC_SEQ_STEP_EN
    input  logic               step,
    input  logic               step_mode,
`endif
    pmcc_sequencer_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_WAIT      = 3'd3,
        S_HALTED    = 3'd4,
        S_STEP_HOLD = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_WAIT  = 4'h2;
    localparam logic [3:0] OP_LSET  = 4'h3;
    localparam logic [3:0] OP_LJMP  = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       loop_cnt_q, loop_cnt_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic              store_q, store_d;
    logic              err_q, err_d;

    logic [3:0]        op;
    logic [15:0]       op16;
    logic [ADDR_W-1:0] tgt;
    state_t            resume_state;

    assign op   = bus.mem_rdata[3:0];
    assign op16 = bus.mem_rdata[23:8];
    assign tgt  = bus.mem_rdata[24 +: ADDR_W];

    // Where execution continues after a DECODE or a finished WAIT.
`ifdef PMCC_SEQ_STEP_EN
    assign resume_state = step_mode ? S_STEP_HOLD : S_FETCH;
`else
    assign resume_state = S_FETCH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= START_ADDR;
            loop_cnt_q <= '0;
            wait_cnt_q <= '0;
            instr_q    <= '0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            loop_cnt_q <= loop_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
            store_q    <= store_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        loop_cnt_d = loop_cnt_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        store_d    = 1'b0;
        err_d      = err_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_d = S_FETCH;
                        pc_d    = START_ADDR;
                        err_d   = 1'b0;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    instr_d = bus.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = resume_state;
                    case (op)
                        OP_NOP:   ;
                        OP_STORE: store_d = 1'b1;
                        OP_WAIT: begin
                            if (op16 != 16'd0) begin
                                state_d    = S_WAIT;
                                wait_cnt_d = op16 - 16'd1;
                            end
                        end
                        OP_LSET:  loop_cnt_d = op16;
                        OP_LJMP: begin
                            if (loop_cnt_q != 16'd0) begin
                                loop_cnt_d = loop_cnt_q - 16'd1;
                                pc_d       = tgt;
                            end
                        end
                        OP_JMP:   pc_d = tgt;
                        OP_HALT:  state_d = S_HALTED;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_HALTED;
                        end
                    endcase
                end
                S_WAIT: begin
                    if (wait_cnt_q == 16'd0) begin
                        state_d = resume_state;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 16'd1;
                    end
                end
`ifdef PMCC_SEQ_STEP_EN
                S_STEP_HOLD: begin
                    if (step) begin
                        state_d = S_FETCH;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_req  = (state_q == S_FETCH);
        bus.mem_addr = (state_q == S_FETCH) ? pc_q : '0;
        bus.store    = store_q;
        bus.instr    = instr_q;
        busy         = (state_q != S_IDLE) && (state_q != S_HALTED);
        done         = (state_q == S_HALTED);
        err          = err_q;
    end

endmodule
